// File: rtl/bound_counter_unit_if.sv
// Command/status bundle between next_state_generator and bound_counter_unit.
// master drives count commands and the pad flick; slave returns the count view.
interface bound_counter_unit_if;
  logic       flick_in;
  logic [1:0] count_state;
  logic [4:0] counter_load;
  logic       counter_load_en;
  logic [4:0] counter;
  logic       flick;
  logic       kickback_match;
  logic [15:0] led;

  modport master (
    output flick_in,
    output count_state,
    output counter_load,
    output counter_load_en,
    input  counter,
    input  flick,
    input  kickback_match,
    input  led
  );

  modport slave (
    input  flick_in,
    input  count_state,
    input  counter_load,
    input  counter_load_en,
    output counter,
    output flick,
    output kickback_match,
    output led
  );
endinterface

// File: rtl/bound_counter_unit.sv
// Saturating 0..16 LED counter with load, flick synchronizer,
// thermometer LED decode and kickback detection.
module bound_counter_unit (
  input  logic                 clk,
  input  logic                 rst_n,
  bound_counter_unit_if.slave  bus
);

  logic       r_sync1;
  logic       r_sync2;
  logic [4:0] r_counter;
  logic [4:0] w_next;
  logic [4:0] w_load;
  logic       w_ld;
  logic       w_up;
  logic       w_dn;
  logic       w_clr;
  logic [15:0] w_led;

  assign w_ld  = bus.counter_load_en;
  assign w_up  = !w_ld && (bus.count_state == 2'b01);
  assign w_dn  = !w_ld && (bus.count_state == 2'b10);
  assign w_clr = !w_ld && (bus.count_state == 2'b11);

  assign w_load = (bus.counter_load > 5'd16) ? 5'd16 : bus.counter_load;

  always_comb begin
    w_next = r_counter;
    unique case (1'b1)
      w_ld:    w_next = w_load;
      w_up:    w_next = (r_counter >= 5'd16) ? 5'd16 : r_counter + 5'd1;
      w_dn:    w_next = (r_counter == 5'd0) ? 5'd0 : r_counter - 5'd1;
      w_clr:   w_next = 5'd0;
      default: w_next = r_counter;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_counter <= 5'd0;
    end else begin
      r_sync1   <= bus.flick_in;
      r_sync2   <= r_sync1;
      r_counter <= w_next;
    end
  end

  always_comb begin
    w_led = '0;
    for (int i = 0; i < 16; i++) begin
      w_led[i] = (5'(i) < r_counter);
    end
  end

  assign bus.counter        = r_counter;
  assign bus.flick          = r_sync2;
  assign bus.led            = w_led;
  assign bus.kickback_match = (bus.count_state == 2'b10) && r_sync2 &&
                              ((r_counter == 5'd5) || (r_counter == 5'd0));

endmodule
